cacheline_adapter: RTL and testbench
====================================

// Module: cacheline_adapter
// PURPOSE
//  Responder for the cache's 256-bit physical-memory port (pmem_read/pmem_write/pmem_address/pmem_rdata/pmem_wdata/pmem_resp).
//  Converts each line request into a 4-beat 64-bit burst on the DRAM-side interface and returns one 256-bit line per read.
//  Sits between the cache datapath/control pair and the burst memory model; one transaction outstanding at a time.
// PARAMETERS
//  LINE_W   256  width of a cache line (bits), must equal 8*2**s_offset of the cache
//  BURST_W  64   width of one DRAM beat (bits)
//  BEATS    LINE_W/BURST_W (=4)  derived localparam, not overridable
// PORTS
//  clk              in   1        single clock, all state updates on rising edge
//  rst              in   1        synchronous, active-high reset
//  pmem_read        in   1        cache line read request, held high until pmem_resp
//  pmem_write       in   1        cache line write request, held high until pmem_resp
//  pmem_address     in   32       line address from cache; bits [4:0] ignored
//  pmem_wdata       in   LINE_W   line to write back, stable while pmem_write high
//  pmem_rdata       out  LINE_W   assembled line, valid in the pmem_resp cycle of a read
//  pmem_resp        out  1        one-cycle completion pulse to the cache
//  dram_read        out  1        burst read request
//  dram_write       out  1        burst write request
//  dram_address     out  32       {pmem_address[31:5],5'b0}, latched at request acceptance
//  dram_wdata       out  BURST_W  current write beat
//  dram_rdata       in   BURST_W  current read beat, valid when dram_resp high
//  dram_resp        in   1        one beat transferred this cycle
// BEHAVIOUR
//  Reset: state IDLE, beat counter 0, pmem_resp=0, dram_read=0, dram_write=0, dram_address=0, dram_wdata=0, pmem_rdata=0.
//  States: IDLE, RD_BURST, WR_BURST, DONE.
//  IDLE: pmem_write high -> latch address+pmem_wdata, WR_BURST; else pmem_read high -> latch address, RD_BURST.
//   Both high same cycle: write wins (read is retried by cache afterwards). Neither: stay.
//  RD_BURST: dram_read=1. Each cycle dram_resp=1: line[BURST_W*k +: BURST_W] <= dram_rdata, k<=k+1.
//   dram_resp=1 with k==BEATS-1 -> DONE, k<=0. Beats need not be back-to-back; resp gaps just stall.
//  WR_BURST: dram_write=1, dram_wdata = latched line[BURST_W*k +: BURST_W]. dram_resp=1 advances k;
//   at k==BEATS-1 -> DONE, k<=0.
//  DONE: pmem_resp=1 for exactly one cycle, dram_read=dram_write=0, then IDLE unconditionally.
//   pmem_rdata holds the last assembled line until the next read completes (unchanged by writes).
//  DONE->IDLE guarantees a still-high pmem_read/write in the cycle after resp is not re-accepted:
//   IDLE requires one further cycle; cache controller drops the request on the edge after pmem_resp.
//  dram_resp while in IDLE or DONE is ignored. dram_address constant for whole burst.
//  Minimum latency: request seen in cycle 0, beats in cycles 1..4, pmem_resp in cycle 5.
//  rst mid-burst: next cycle IDLE, strobes low, k=0, partial line discarded, no pmem_resp issued.
//  Beat counter width $clog2(BEATS); wraps only via explicit reset to 0 on last beat.
// STRUCTURE
//  Package cache_pkg: typedef enum logic [1:0] {IDLE,RD_BURST,WR_BURST,DONE} adapter_state_t;
//   localparams LINE_W=256, BURST_W=64 shared with cache_datapath.
//  Single module: state FSM, beat counter, LINE_W read shift/assembly register, LINE_W write buffer.
//  No sub-module; FSM outputs decoded combinationally from state.
// TESTING
//  1 read, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> dram_address 0x0000_1220,
//    pmem_resp in cycle 5, pmem_rdata = {beat3,beat2,beat1,beat0}.
//  2 write, pmem_wdata = 256'h{D3,C2,B1,A0} (64-bit words) -> dram_wdata A0,B1,C2,D3 in order, one pmem_resp.
//  3 read with dram_resp gaps (1,0,0,1,1,0,1) -> correct line, pmem_resp 1 cycle after 4th beat, dram_read high throughout.
//  4 pmem_read and pmem_write both high in IDLE -> dram_write burst only, dram_read stays 0.
//  5 rst asserted after 2 read beats -> IDLE next cycle, dram_read 0, no pmem_resp; fresh read then completes correctly.
//  6 pmem_read held high through DONE -> exactly one pmem_resp per burst; stray dram_resp in IDLE changes nothing.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, state encoding and address helper for the cache-line to DRAM burst adapter.
package cache_pkg;

   localparam int LINE_W   = 256;
   localparam int BURST_W  = 64;
   localparam int BEATS    = LINE_W / BURST_W;
   localparam int BEAT_W   = $clog2(BEATS);
   localparam int LINE_B   = LINE_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } adapter_state_t;

   // Line-aligned address: byte-offset bits within the line are cleared.
   function automatic logic [31:0] line_address(input logic [31:0] addr);
      return addr & ~32'(LINE_B - 1);
   endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache physical-memory port plus DRAM burst port; slave is the adapter's view, master the environment's.
interface cacheline_adapter_if;
   import cache_pkg::*;

   logic                pmem_read;
   logic                pmem_write;
   logic [31:0]         pmem_address;
   logic [LINE_W-1:0]   pmem_wdata;
   logic [LINE_W-1:0]   pmem_rdata;
   logic                pmem_resp;

   logic                dram_read;
   logic                dram_write;
   logic [31:0]         dram_address;
   logic [BURST_W-1:0]  dram_wdata;
   logic [BURST_W-1:0]  dram_rdata;
   logic                dram_resp;

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp,
      output dram_read, dram_write, dram_address, dram_wdata,
      input  dram_rdata, dram_resp
   );

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp,
      input  dram_read, dram_write, dram_address, dram_wdata,
      output dram_rdata, dram_resp
   );

endinterface

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit line request into a 4-beat 64-bit DRAM burst; one transaction at a time.
//  state    | meaning
//  IDLE     | waiting for pmem_write (priority) or pmem_read
//  RD_BURST | dram_read high, collecting beats on dram_resp
//  WR_BURST | dram_write high, presenting buffered beats on dram_wdata
//  DONE     | one-cycle pmem_resp, then back to IDLE
module cacheline_adapter
   import cache_pkg::*;
(
   input logic                clk,
   input logic                rst,
   cacheline_adapter_if.slave bus
);

   adapter_state_t       state_q, state_d;
   logic [BEAT_W-1:0]    beat_q, beat_d;
   logic [31:0]          addr_q, addr_d;
   logic [LINE_W-1:0]    buf_q, buf_d;
   logic [LINE_W-1:0]    rdata_q, rdata_d;
   logic                 last_beat;

   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

   // buf_q holds the write line, or the partial read line; rdata_q only updates on read completion.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.pmem_write) begin
               addr_d  = line_address(bus.pmem_address);
               buf_d   = bus.pmem_wdata;
               beat_d  = '0;
               state_d = WR_BURST;
            end else if (bus.pmem_read) begin
               addr_d  = line_address(bus.pmem_address);
               beat_d  = '0;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            if (bus.dram_resp) begin
               if (last_beat) begin
                  rdata_d = {bus.dram_rdata, buf_q[LINE_W-BURST_W-1:0]};
                  beat_d  = '0;
                  state_d = DONE;
               end else begin
                  buf_d[BURST_W*beat_q +: BURST_W] = bus.dram_rdata;
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         WR_BURST: begin
            if (bus.dram_resp) begin
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.pmem_resp    = (state_q == DONE);
   assign bus.pmem_rdata   = rdata_q;
   assign bus.dram_read    = (state_q == RD_BURST);
   assign bus.dram_write   = (state_q == WR_BURST);
   assign bus.dram_address = addr_q;
   assign bus.dram_wdata   = (state_q == WR_BURST) ? buf_q[BURST_W*beat_q +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed and randomized bench for cacheline_adapter against a transaction-level line/beat model.
module tb_cacheline_adapter;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cacheline_adapter_if bus ();

   cacheline_adapter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [LINE_W-1:0] exp_rdata;
   logic [31:0]       exp_addr;
   int                last_lat;
   logic [63:0]       wq[$];

   task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W/32; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   task automatic check_idle(input string tag);
      sample();
      check({tag, "_resp"},   bus.pmem_resp, 1'b0);
      check({tag, "_rd"},     bus.dram_read, 1'b0);
      check({tag, "_wr"},     bus.dram_write, 1'b0);
      check({tag, "_wdata"},  bus.dram_wdata, 64'h0);
      check({tag, "_rdata"},  bus.pmem_rdata, exp_rdata);
      check({tag, "_addr"},   bus.dram_address, exp_addr);
   endtask

   // Read: beats delivered according to pat (LSB first) or randomly; line = {beat3,beat2,beat1,beat0}.
   task automatic do_read(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                          input bit use_pat, input logic [15:0] pat, input string tag);
      int k;
      int cyc;
      int idx;
      bit r;
      k = 0; idx = 0;
      bus.pmem_read    = 1'b1;
      bus.pmem_address = addr;
      exp_addr = {addr[31:5], 5'b0};
      tick();
      cyc = 1;
      while (k < 4 && cyc < 64) begin
         if (use_pat) r = (idx < 16) ? pat[idx] : 1'b1;
         else         r = ($urandom_range(0, 2) != 0);
         idx++;
         bus.dram_resp  = r;
         bus.dram_rdata = r ? line[64*k +: 64] : {$urandom, $urandom};
         sample();
         check({tag, "_dram_read"}, bus.dram_read, 1'b1);
         check({tag, "_dram_write"}, bus.dram_write, 1'b0);
         check({tag, "_early_resp"}, bus.pmem_resp, 1'b0);
         check({tag, "_dram_addr"}, bus.dram_address, exp_addr);
         if (r) k++;
         tick();
         cyc++;
      end
      bus.dram_resp = 1'b0;
      check({tag, "_beats_timeout"}, LINE_W'(k), LINE_W'(4));
      exp_rdata = line;
      last_lat  = cyc;
      sample();
      check({tag, "_resp"}, bus.pmem_resp, 1'b1);
      check({tag, "_rd_done"}, bus.dram_read, 1'b0);
      check({tag, "_rdata"}, bus.pmem_rdata, exp_rdata);
      tick();
      bus.pmem_read = 1'b0;
      sample();
      check({tag, "_resp_once"}, bus.pmem_resp, 1'b0);
      check({tag, "_rd_after"}, bus.dram_read, 1'b0);
      check({tag, "_rdata_hold"}, bus.pmem_rdata, exp_rdata);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                           input bit also_read, input string tag);
      int k;
      int cyc;
      bit r;
      k = 0;
      wq.delete();
      bus.pmem_write   = 1'b1;
      bus.pmem_read    = also_read;
      bus.pmem_address = addr;
      bus.pmem_wdata   = line;
      exp_addr = {addr[31:5], 5'b0};
      tick();
      cyc = 1;
      while (k < 4 && cyc < 64) begin
         r = ($urandom_range(0, 2) != 0);
         bus.dram_resp  = r;
         bus.dram_rdata = {$urandom, $urandom};
         sample();
         check({tag, "_dram_write"}, bus.dram_write, 1'b1);
         check({tag, "_dram_read"}, bus.dram_read, 1'b0);
         check({tag, "_early_resp"}, bus.pmem_resp, 1'b0);
         check({tag, "_dram_addr"}, bus.dram_address, exp_addr);
         check({tag, "_wdata"}, bus.dram_wdata, line[64*k +: 64]);
         if (r) begin
            wq.push_back(bus.dram_wdata);
            k++;
         end
         tick();
         cyc++;
      end
      bus.dram_resp = 1'b0;
      check({tag, "_beats_timeout"}, LINE_W'(k), LINE_W'(4));
      sample();
      check({tag, "_resp"}, bus.pmem_resp, 1'b1);
      check({tag, "_wr_done"}, bus.dram_write, 1'b0);
      check({tag, "_rdata_kept"}, bus.pmem_rdata, exp_rdata);
      tick();
      bus.pmem_write = 1'b0;
      bus.pmem_read  = 1'b0;
      sample();
      check({tag, "_resp_once"}, bus.pmem_resp, 1'b0);
      check({tag, "_wr_after"}, bus.dram_write, 1'b0);
      check({tag, "_rd_after"}, bus.dram_read, 1'b0);
   endtask

   initial begin
      logic [LINE_W-1:0] line;
      logic [31:0]       addr;
      int                kind;

      rst = 1'b1;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      bus.dram_rdata   = '0;
      bus.dram_resp    = 1'b0;
      exp_rdata = '0;
      exp_addr  = '0;
      tick();
      tick();
      check_idle("reset");
      tick();
      rst = 1'b0;

      // 1: back-to-back read
      line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      do_read(32'h0000_1234, line, 1'b1, 16'hFFFF, "t1");
      check("t1_addr_const", exp_addr, 32'h0000_1220);
      check("t1_latency", LINE_W'(last_lat), LINE_W'(5));

      // 2: write beat order
      line = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
              64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
      do_write(32'h0000_8040, line, 1'b0, "t2");
      check("t2_nbeats", LINE_W'(wq.size()), LINE_W'(4));
      if (wq.size() == 4) begin
         check("t2_beat0", wq[0], 64'hA0A0_A0A0_A0A0_A0A0);
         check("t2_beat1", wq[1], 64'hB1B1_B1B1_B1B1_B1B1);
         check("t2_beat2", wq[2], 64'hC2C2_C2C2_C2C2_C2C2);
         check("t2_beat3", wq[3], 64'hD3D3_D3D3_D3D3_D3D3);
      end

      // 3: read with response gaps 1,0,0,1,1,0,1
      line = rand_line();
      do_read(32'hABCD_EF1F, line, 1'b1, 16'b0000_0000_0101_1001, "t3");
      check("t3_latency", LINE_W'(last_lat), LINE_W'(8));

      // 4: read and write together -> write only
      do_write(32'h1000_0000, rand_line(), 1'b1, "t4");
      do_read(32'h1000_0000, rand_line(), 1'b0, 16'h0, "t4r");

      // 5: reset mid read burst
      bus.pmem_read    = 1'b1;
      bus.pmem_address = 32'h2222_0060;
      tick();
      for (int i = 0; i < 2; i++) begin
         bus.dram_resp  = 1'b1;
         bus.dram_rdata = {$urandom, $urandom};
         tick();
      end
      bus.dram_resp = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.pmem_read = 1'b0;
      exp_rdata = '0;
      exp_addr  = '0;
      check_idle("t5_after_rst");
      tick();
      check_idle("t5_idle2");
      tick();
      do_read(32'h2222_0060, rand_line(), 1'b1, 16'hFFFF, "t5r");

      // 6: stray dram_resp while idle, then a clean read
      for (int i = 0; i < 3; i++) begin
         bus.dram_resp  = 1'b1;
         bus.dram_rdata = {$urandom, $urandom};
         check_idle("t6_stray");
         tick();
      end
      bus.dram_resp = 1'b0;
      do_read(32'h0BAD_F00D, rand_line(), 1'b0, 16'h0, "t6r");

      // randomized mix
      for (int n = 0; n < 25; n++) begin
         kind = $urandom_range(0, 2);
         addr = $urandom;
         line = rand_line();
         if (kind == 0) do_read(addr, line, 1'b0, 16'h0, "rnd_rd");
         else           do_write(addr, line, kind == 2, "rnd_wr");
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            bus.dram_resp  = $urandom_range(0, 1);
            bus.dram_rdata = {$urandom, $urandom};
            tick();
         end
         bus.dram_resp = 1'b0;
         check_idle("rnd_idle");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
